// File: rtl/uart_rx_packetiser_if.sv
// Packet beat type and the byte-in / packet-out bundle between the UART
// receiver, the packetiser and Control.
package uart_rx_packetiser_pkg;
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Destination;
    logic [7:0] Source;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;
endpackage

interface uart_rx_packetiser_if;
  import uart_rx_packetiser_pkg::*;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  UART_PACKET opRxPacket;
  logic [7:0] opDropCount;

  modport master (output ipRxData, ipRxValid, input opRxPacket, opDropCount);
  modport slave  (input ipRxData, ipRxValid, output opRxPacket, opDropCount);
endinterface

// File: rtl/uart_rx_packetiser.sv
// Sync-hunting UART frame parser: header capture, one registered beat per
// payload byte, idle timeout recovery and a saturating drop counter.
module uart_rx_packetiser
  import uart_rx_packetiser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          ipClk,
  input  logic          ipReset,
  uart_rx_packetiser_if.slave bus
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {HUNT, DEST, SRC, LEN, DATA} state_t;

  state_t     r_state;
  logic       r_run;
  logic [IW-1:0] r_idle;
  logic [7:0] r_dest, r_src, r_len, r_rem;
  logic [7:0] r_drop;
  UART_PACKET r_pkt;

  logic w_byte, w_timeout, w_drop_sat;

  // Reset release takes one edge to reach r_run, so bytes count from the
  // second edge after ipReset rises.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  assign w_byte     = bus.ipRxValid & r_run;
  assign w_timeout  = !w_byte && (r_state != HUNT) &&
                      (r_idle == IW'(TIMEOUT_CYCLES - 1));
  assign w_drop_sat = (r_drop == 8'hFF);

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_state <= HUNT;
      r_idle  <= '0;
      r_dest  <= '0;
      r_src   <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_drop  <= '0;
      r_pkt   <= '0;
    end else begin
      r_pkt.Valid <= 1'b0;
      r_pkt.SoP   <= 1'b0;
      r_pkt.EoP   <= 1'b0;
      if (w_byte) begin
        r_idle <= '0;
        case (r_state)
          HUNT: begin
            if (bus.ipRxData == SYNC_BYTE) r_state <= DEST;
            else if (!w_drop_sat)          r_drop  <= r_drop + 8'd1;
          end
          DEST: begin
            r_dest  <= bus.ipRxData;
            r_state <= SRC;
          end
          SRC: begin
            r_src   <= bus.ipRxData;
            r_state <= LEN;
          end
          LEN: begin
            r_len   <= bus.ipRxData;
            r_rem   <= bus.ipRxData;
            r_state <= (bus.ipRxData == 8'd0) ? HUNT : DATA;
          end
          DATA: begin
            r_pkt.Valid <= 1'b1;
            r_pkt.SoP   <= (r_rem == r_len);
            r_pkt.EoP   <= (r_rem == 8'd1);
            r_pkt.Data  <= bus.ipRxData;
            // Header on the output only moves at a frame's first beat.
            if (r_rem == r_len) begin
              r_pkt.Destination <= r_dest;
              r_pkt.Source      <= r_src;
              r_pkt.Length      <= r_len;
            end
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) r_state <= HUNT;
          end
          default: r_state <= HUNT;
        endcase
      end else if (r_state != HUNT) begin
        if (w_timeout) begin
          r_state <= HUNT;
          r_idle  <= '0;
          if (!w_drop_sat) r_drop <= r_drop + 8'd1;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  assign bus.opRxPacket  = r_pkt;
  assign bus.opDropCount = r_drop;
endmodule
